nt_subckt_test_sequencer: RTL and testbench

Controller that sequences pattern-based comparison of NUM_DUT replicated Nt-node subcircuit instances. Instance 0 is the golden copy; instances 1..NUM_DUT-1 are suspect copies.
The block resets the instances, drives a shared pseudo-random input vector, waits for the internal flop pipeline to settle, then captures and compares outputs pattern by pattern.
It reports sticky per-instance mismatch flags and the first failing pattern index. It sits between the trojan-detection bench top level and the subcircuit array.

---
 rtl/nt_subckt_test_sequencer.sv | 179 +++++++++++++++++
 tb/tb_nt_subckt_test_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nt_subckt_test_sequencer.sv
// Test sequencer for an array of replicated Nt-node subcircuits.
// Instance 0 is the golden reference; every other enabled instance is
// compared against it bit-for-bit on each applied pseudo-random pattern.
// Mismatch flags are sticky for the run and the index of the first failing
// pattern is kept for the bench top level.
module nt_subckt_test_sequencer #(
    parameter int NUM_DUT = 4,
    parameter int PAT_W   = 5,
    parameter int NUM_PAT = 16,
    parameter int SETTLE  = 2,
    parameter int RST_CYC = 2,
    localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic               CLK,
    input  logic               RSTB,
    input  logic               start,
    input  logic               abort,
    input  logic [PAT_W-1:0]   seed,
    input  logic [NUM_DUT-1:0] dut_en,
    input  logic [NUM_DUT-1:0] dut_out,
    output logic [PAT_W-1:0]   dut_in,
    output logic               dut_rstb,
    output logic               busy,
    output logic               done,
    output logic [NUM_DUT-1:0] mismatch,
    output logic               fail_valid,
    output logic [IDX_W-1:0]   first_fail_idx
);

    // One counter serves both the instance-reset hold and the settle hold.
    localparam int CNT_MAX = (SETTLE > RST_CYC) ? SETTLE : RST_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST     = 3'd1,
        ST_APPLY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [PAT_W-1:0]   lfsr_r;
    logic [PAT_W-1:0]   dut_in_r;
    logic               dut_rstb_r;
    logic               busy_r;
    logic               done_r;
    logic [NUM_DUT-1:0] mismatch_r;
    logic               fail_valid_r;
    logic [IDX_W-1:0]   first_fail_idx_r;

    logic [NUM_DUT-1:0] fail_bits_s;
    logic [NUM_DUT-1:0] new_bits_s;
    logic [PAT_W-1:0]   seed_load_s;

    // Fibonacci LFSR step; the all-zero state is unreachable from a
    // non-zero seed, so the pattern stream never stalls.
    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] v);
        return {v[PAT_W-2:0], v[PAT_W-1] ^ v[PAT_W-3]};
    endfunction

    // A zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_load_s = (seed == {PAT_W{1'b0}}) ? {{(PAT_W-1){1'b0}}, 1'b1} : seed;

    // Per-instance disagreement with the golden copy; instance 0 never flags.
    always_comb begin
        fail_bits_s = {NUM_DUT{1'b0}};
        for (int i = 0; i < NUM_DUT; i++) begin
            fail_bits_s[i] = (i != 0) ? (dut_en[i] & (dut_out[i] ^ dut_out[0])) : 1'b0;
        end
        new_bits_s = fail_bits_s & ~mismatch_r;
    end

    // Main sequencer: state, counters, LFSR and all registered outputs.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_r          <= ST_IDLE;
            cnt_r            <= {CNT_W{1'b0}};
            idx_r            <= {IDX_W{1'b0}};
            lfsr_r           <= {{(PAT_W-1){1'b0}}, 1'b1};
            dut_in_r         <= {PAT_W{1'b0}};
            dut_rstb_r       <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            mismatch_r       <= {NUM_DUT{1'b0}};
            fail_valid_r     <= 1'b0;
            first_fail_idx_r <= {IDX_W{1'b0}};
        end else if (abort && (state_r != ST_IDLE)) begin
            // Results gathered so far stay visible; instances get one reset cycle.
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            dut_rstb_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r          <= ST_RST;
                        cnt_r            <= {CNT_W{1'b0}};
                        idx_r            <= {IDX_W{1'b0}};
                        lfsr_r           <= seed_load_s;
                        dut_rstb_r       <= 1'b0;
                        busy_r           <= 1'b1;
                        mismatch_r       <= {NUM_DUT{1'b0}};
                        fail_valid_r     <= 1'b0;
                        first_fail_idx_r <= {IDX_W{1'b0}};
                    end else begin
                        dut_rstb_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                ST_RST: begin
                    if (cnt_r == CNT_W'(RST_CYC - 1)) begin
                        state_r    <= ST_APPLY;
                        cnt_r      <= {CNT_W{1'b0}};
                        dut_rstb_r <= 1'b1;
                        dut_in_r   <= lfsr_r;
                    end else begin
                        cnt_r      <= cnt_r + CNT_W'(1);
                        dut_rstb_r <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (cnt_r == CNT_W'(SETTLE - 1)) begin
                        state_r <= ST_CAPTURE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    mismatch_r <= mismatch_r | fail_bits_s;
                    if ((new_bits_s != {NUM_DUT{1'b0}}) && !fail_valid_r) begin
                        fail_valid_r     <= 1'b1;
                        first_fail_idx_r <= idx_r;
                    end else begin
                        fail_valid_r <= fail_valid_r;
                    end
                    if (idx_r == IDX_W'(NUM_PAT - 1)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        // Instance flops keep their state across patterns on purpose.
                        state_r  <= ST_APPLY;
                        idx_r    <= idx_r + IDX_W'(1);
                        lfsr_r   <= lfsr_next(lfsr_r);
                        dut_in_r <= lfsr_next(lfsr_r);
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    dut_rstb_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= {CNT_W{1'b0}};
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    dut_rstb_r <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in         = dut_in_r;
    assign dut_rstb       = dut_rstb_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign mismatch       = mismatch_r;
    assign fail_valid     = fail_valid_r;
    assign first_fail_idx = first_fail_idx_r;

endmodule

// File: tb/tb_nt_subckt_test_sequencer.sv
// Self-checking bench for nt_subckt_test_sequencer with default parameters.
// A behavioural array model answers dut_in with a random golden truth table
// plus per-instance inversion faults starting at chosen pattern indices.
module tb_nt_subckt_test_sequencer;

    localparam int NUM_DUT = 4;
    localparam int PAT_W   = 5;
    localparam int NUM_PAT = 16;
    localparam int SETTLE  = 2;
    localparam int RST_CYC = 2;
    localparam int RUN_LEN = RST_CYC + NUM_PAT * (SETTLE + 1);
    localparam int NO_FAULT = 99;

    logic               CLK = 1'b0;
    logic               RSTB;
    logic               start;
    logic               abort;
    logic [PAT_W-1:0]   seed;
    logic [NUM_DUT-1:0] dut_en;
    logic [NUM_DUT-1:0] dut_out;
    logic [PAT_W-1:0]   dut_in;
    logic               dut_rstb;
    logic               busy;
    logic               done;
    logic [NUM_DUT-1:0] mismatch;
    logic               fail_valid;
    logic [3:0]         first_fail_idx;

    int checks = 0;
    int errors = 0;

    logic [PAT_W-1:0]   seq_g [NUM_PAT];
    logic [PAT_W-1:0]   obs_in [NUM_PAT];
    int                 fstart [NUM_DUT];
    logic               tt [32];
    logic [NUM_DUT-1:0] exp_mm;
    logic               exp_fv;
    int                 exp_ffi;
    int                 pidx_s;

    nt_subckt_test_sequencer #(
        .NUM_DUT(NUM_DUT), .PAT_W(PAT_W), .NUM_PAT(NUM_PAT),
        .SETTLE(SETTLE), .RST_CYC(RST_CYC)
    ) dut (
        .CLK(CLK), .RSTB(RSTB), .start(start), .abort(abort), .seed(seed),
        .dut_en(dut_en), .dut_out(dut_out), .dut_in(dut_in), .dut_rstb(dut_rstb),
        .busy(busy), .done(done), .mismatch(mismatch), .fail_valid(fail_valid),
        .first_fail_idx(first_fail_idx)
    );

    always #5 CLK = ~CLK;

    // Subcircuit array model: golden truth table, faulty copies inverted from fstart on.
    always_comb begin
        pidx_s = -1;
        for (int p = 0; p < NUM_PAT; p++) begin
            if (seq_g[p] === dut_in) pidx_s = p;
        end
        for (int i = 0; i < NUM_DUT; i++) begin
            dut_out[i] = tt[dut_in] ^ ((i != 0) && (pidx_s >= 0) && (pidx_s >= fstart[i]));
        end
    end

    function automatic logic [PAT_W-1:0] model_step(input logic [PAT_W-1:0] v);
        int x;
        x = int'(v);
        return PAT_W'(((x * 2) % 32) + ((((x / 16) % 2) + ((x / 4) % 2)) % 2));
    endfunction

    task automatic setup_model(input logic [PAT_W-1:0] sd, input logic [NUM_DUT-1:0] en);
        logic [PAT_W-1:0] v;
        int first;
        v = (sd == 5'd0) ? 5'd1 : sd;
        for (int p = 0; p < NUM_PAT; p++) begin
            seq_g[p] = v;
            v = model_step(v);
        end
        exp_mm = 4'd0;
        first = NUM_PAT;
        for (int i = 1; i < NUM_DUT; i++) begin
            if (en[i] && fstart[i] < NUM_PAT) begin
                exp_mm[i] = 1'b1;
                if (fstart[i] < first) first = fstart[i];
            end
        end
        exp_fv  = (exp_mm != 4'd0);
        exp_ffi = exp_fv ? first : 0;
    endtask

    task automatic clear_faults();
        for (int i = 0; i < NUM_DUT; i++) fstart[i] = NO_FAULT;
    endtask

    task automatic random_table();
        for (int j = 0; j < 32; j++) tt[j] = 1'($urandom_range(0, 1));
    endtask

    // Full run with cycle-exact checks; extra_c >= 0 pulses a start while busy.
    task automatic run_and_check(input string name, input logic [PAT_W-1:0] sd,
                                 input logic [NUM_DUT-1:0] en, input int extra_c);
        int p;
        setup_model(sd, en);
        dut_en = en;
        seed   = sd;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int c = 0; c <= RUN_LEN + 1; c++) begin
            if (c > 0) @(negedge CLK);
            start = (c == extra_c) ? 1'b1 : 1'b0;
            checks++;
            if (dut_rstb !== ((c >= RST_CYC) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s dut_rstb c=%0d got %b want %b", name, c, dut_rstb, c >= RST_CYC);
            end
            checks++;
            if (busy !== ((c <= RUN_LEN) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s busy c=%0d got %b want %b", name, c, busy, c <= RUN_LEN);
            end
            checks++;
            if (done !== ((c == RUN_LEN) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s done c=%0d got %b want %b", name, c, done, c == RUN_LEN);
            end
            if (c >= RST_CYC && c < RUN_LEN) begin
                p = (c - RST_CYC) / (SETTLE + 1);
                if ((c - RST_CYC) % (SETTLE + 1) == 0) obs_in[p] = dut_in;
                checks++;
                if (dut_in !== seq_g[p]) begin
                    errors++;
                    $display("FAIL %s dut_in c=%0d pat=%0d got %h want %h", name, c, p, dut_in, seq_g[p]);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (mismatch !== exp_mm) begin
            errors++;
            $display("FAIL %s mismatch got %b want %b", name, mismatch, exp_mm);
        end
        checks++;
        if (fail_valid !== exp_fv) begin
            errors++;
            $display("FAIL %s fail_valid got %b want %b", name, fail_valid, exp_fv);
        end
        checks++;
        if (first_fail_idx !== 4'(exp_ffi)) begin
            errors++;
            $display("FAIL %s first_fail_idx got %0d want %0d", name, first_fail_idx, exp_ffi);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({dut_in, dut_rstb, busy, done, mismatch, fail_valid, first_fail_idx} !== 17'd0) begin
            errors++;
            $display("FAIL %s reset outputs got in=%h rstb=%b busy=%b done=%b mm=%b fv=%b ffi=%0d want all zero",
                     name, dut_in, dut_rstb, busy, done, mismatch, fail_valid, first_fail_idx);
        end
    endtask

    task automatic test_reset();
        RSTB = 1'b0; start = 1'b0; abort = 1'b0; seed = 5'd0; dut_en = 4'd0;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RSTB = 1'b1;
        @(negedge CLK);
        checks++;
        if (dut_rstb !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got rstb=%b busy=%b want 1 0", dut_rstb, busy);
        end
    endtask

    task automatic test_clean_seed1();
        logic [PAT_W-1:0] lit [5];
        lit = '{5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010};
        clear_faults();
        random_table();
        run_and_check("clean_seed1", 5'd1, 4'b1111, -1);
        for (int p = 0; p < 5; p++) begin
            checks++;
            if (obs_in[p] !== lit[p]) begin
                errors++;
                $display("FAIL seq_literal pat=%0d got %b want %b", p, obs_in[p], lit[p]);
            end
        end
    endtask

    task automatic test_fault_inst2();
        clear_faults();
        random_table();
        fstart[2] = 5;
        run_and_check("fault_en1110", 5'd1, 4'b1110, -1);
        checks++;
        if (mismatch !== 4'b0100 || fail_valid !== 1'b1 || first_fail_idx !== 4'd5) begin
            errors++;
            $display("FAIL fault_literal got mm=%b fv=%b ffi=%0d want 0100 1 5", mismatch, fail_valid, first_fail_idx);
        end
        run_and_check("fault_en1010", 5'd1, 4'b1010, -1);
        checks++;
        if (mismatch !== 4'b0000 || fail_valid !== 1'b0) begin
            errors++;
            $display("FAIL masked_literal got mm=%b fv=%b want 0000 0", mismatch, fail_valid);
        end
    endtask

    task automatic test_seed_zero();
        clear_faults();
        random_table();
        run_and_check("seed_zero", 5'd0, 4'b1111, -1);
        checks++;
        if (obs_in[0] !== 5'b00001) begin
            errors++;
            $display("FAIL seed_zero_first got %b want 00001", obs_in[0]);
        end
    endtask

    task automatic test_abort();
        clear_faults();
        random_table();
        fstart[1] = 0;
        setup_model(5'd7, 4'b0010);
        dut_en = 4'b0010;
        seed   = 5'd7;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (RST_CYC + 2 * (SETTLE + 1)) @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dut_rstb !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle got busy=%b done=%b rstb=%b want 0 0 0", busy, done, dut_rstb);
        end
        checks++;
        if (mismatch !== 4'b0010 || fail_valid !== 1'b1 || first_fail_idx !== 4'd0) begin
            errors++;
            $display("FAIL abort_retain got mm=%b fv=%b ffi=%0d want 0010 1 0", mismatch, fail_valid, first_fail_idx);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || dut_rstb !== 1'b1) begin
                errors++;
                $display("FAIL abort_idle c=%0d got done=%b busy=%b rstb=%b want 0 0 1", c, done, busy, dut_rstb);
            end
        end
        clear_faults();
        run_and_check("after_abort", 5'd7, 4'b1110, -1);
        // abort together with start in IDLE: start wins
        @(negedge CLK);
        start = 1'b1; abort = 1'b1;
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || dut_rstb !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_idle got busy=%b rstb=%b want 1 0", busy, dut_rstb);
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_rst got busy=%b want 0", busy);
        end
    endtask

    task automatic test_rstb_mid_capture();
        clear_faults();
        random_table();
        fstart[1] = 0;
        setup_model(5'd19, 4'b0010);
        dut_en = 4'b0010;
        seed   = 5'd19;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (RST_CYC + 2 * (SETTLE + 1) - 1) @(negedge CLK);
        checks++;
        if (mismatch !== 4'b0010) begin
            errors++;
            $display("FAIL pre_rstb_mismatch got %b want 0010", mismatch);
        end
        #2 RSTB = 1'b0;
        #1 check_reset_values("rstb_async");
        @(negedge CLK);
        RSTB = 1'b1;
        clear_faults();
        run_and_check("after_rstb", 5'd19, 4'b1111, -1);
    endtask

    task automatic test_random_runs();
        logic [PAT_W-1:0]   sd;
        logic [NUM_DUT-1:0] en;
        int                 xc;
        for (int r = 0; r < 6; r++) begin
            random_table();
            for (int i = 0; i < NUM_DUT; i++) fstart[i] = int'($urandom_range(0, 24));
            sd = PAT_W'($urandom_range(0, 31));
            en = NUM_DUT'($urandom_range(0, 15));
            xc = (r % 2 == 0) ? int'($urandom_range(0, RUN_LEN - 1)) : -1;
            run_and_check($sformatf("random%0d", r), sd, en, xc);
        end
    endtask

    initial begin
        for (int p = 0; p < NUM_PAT; p++) seq_g[p] = 5'd0;
        for (int j = 0; j < 32; j++) tt[j] = 1'b0;
        clear_faults();
        test_reset();
        test_clean_seed1();
        test_fault_inst2();
        test_seed_zero();
        test_abort();
        test_rstb_mid_capture();
        test_random_runs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
